// File: rtl/apb_master_ctrl_if.sv
// rtl/apb_master_ctrl_if.sv - local command/response and APB signal bundle for apb_master_ctrl
interface apb_master_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic              load;
    logic              fetch;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    // master: the controller; slave: the local requester plus the APB target
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, pwrite, pwdata, psel, penable, load, fetch
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, pwrite, pwdata, psel, penable, load, fetch
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - APB initiator turning single-beat commands into SETUP/ACCESS transfers
module apb_master_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic                pclk,
    input logic                prst,
    apb_master_ctrl_if.master  bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0] paddr_q, paddr_nxt;
    logic              pwrite_q, pwrite_nxt;
    logic [DATA_W-1:0] pwdata_q, pwdata_nxt;
    logic              psel_q, psel_nxt;
    logic              penable_q, penable_nxt;
    logic              rsp_valid_q, rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_nxt;
    logic              rsp_err_q, rsp_err_nxt;
    logic              rsp_timeout_q, rsp_timeout_nxt;

    always_ff @(posedge pclk) begin
        if (prst) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            wait_cnt      <= wait_cnt_nxt;
            paddr_q       <= paddr_nxt;
            pwrite_q      <= pwrite_nxt;
            pwdata_q      <= pwdata_nxt;
            psel_q        <= psel_nxt;
            penable_q     <= penable_nxt;
            rsp_valid_q   <= rsp_valid_nxt;
            rsp_rdata_q   <= rsp_rdata_nxt;
            rsp_err_q     <= rsp_err_nxt;
            rsp_timeout_q <= rsp_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        paddr_nxt       = paddr_q;
        pwrite_nxt      = pwrite_q;
        pwdata_nxt      = pwdata_q;
        psel_nxt        = psel_q;
        penable_nxt     = penable_q;
        rsp_valid_nxt   = rsp_valid_q;
        rsp_rdata_nxt   = rsp_rdata_q;
        rsp_err_nxt     = rsp_err_q;
        rsp_timeout_nxt = rsp_timeout_q;
        case (state)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_nxt   = bus.cmd_addr;
                    pwrite_nxt  = bus.cmd_write;
                    pwdata_nxt  = bus.cmd_write ? bus.cmd_wdata : '0;
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                penable_nxt  = 1'b1;
                wait_cnt_nxt = '0;
                state_nxt    = ACCESS;
            end
            ACCESS: begin
                // a ready slave wins over a timeout expiring on the same edge
                if (bus.pready) begin
                    rsp_rdata_nxt   = pwrite_q ? '0 : bus.prdata;
                    rsp_err_nxt     = bus.pslverr;
                    rsp_timeout_nxt = 1'b0;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = RESP;
                end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                    rsp_rdata_nxt   = '0;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = RESP;
                end else if (wait_cnt != CNT_MAX) begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cmd_ready   = (state == IDLE) && !prst;
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.load        = psel_q && pwrite_q;
    assign bus.fetch       = psel_q && !pwrite_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule
